// File: rtl/phrase_sequencer.sv
// Phrase sequencer: queues 4-bit phrase ids and plays them one at a time
// through an external address table and audio controller, with a fixed
// silent gap between consecutive phrases and a bounded start handshake.
module phrase_sequencer #(
  parameter int unsigned DEPTH       = 8,             // queue depth, power of two (>= 2)
  parameter logic [31:0] GAP_CYCLES  = 32'd2500000,   // silent cycles between phrases
  parameter logic [31:0] ACK_TIMEOUT = 32'd64         // max cycles waiting for play_finish to fall
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [3:0]  push_id,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        err,
  output logic [3:0]  lut_id,
  input  logic [23:0] lut_start,
  input  logic [23:0] lut_end,
  output logic [23:0] start_address,
  output logic [23:0] end_address,
  output logic        play_start,
  input  logic        play_finish
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_PLAY,
    S_GAP
  } state_t;

  // ------------------------------------------------------------------
  // Phrase queue storage and bookkeeping
  // ------------------------------------------------------------------
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // ------------------------------------------------------------------
  // Sequencer state and registered outputs
  // ------------------------------------------------------------------
  state_t        r_state;
  logic [31:0]   r_cnt;
  logic          r_play_start;
  logic          r_busy;
  logic          r_err;
  logic [23:0]   r_start_address;
  logic [23:0]   r_end_address;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_ok;
  logic [31:0]   w_cnt_inc;
  logic          w_tmo_hit;
  logic          w_gap_hit;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // The head is consumed in LOAD; an empty queue there means a flush raced
  // the IDLE/GAP decision, in which case nothing is popped.
  assign w_pop = (r_state == S_LOAD) && !w_empty;

  // A full queue still accepts a push when the head leaves in the same cycle.
  // Flush wins over a concurrent push.
  assign w_push_ok = push && !flush && (!w_full || w_pop);

  // Shared state counter saturates instead of wrapping.
  assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : (r_cnt + 32'd1);

  // Counter holds the number of cycles already spent in the current state,
  // so the hit fires on the last cycle of the allowed window.
  assign w_tmo_hit = (ACK_TIMEOUT == 32'd0) || (r_cnt >= (ACK_TIMEOUT - 32'd1));
  assign w_gap_hit = (GAP_CYCLES  == 32'd0) || (r_cnt >= (GAP_CYCLES  - 32'd1));

  assign full          = w_full;
  assign empty         = w_empty;
  assign busy          = r_busy;
  assign err           = r_err;
  assign lut_id        = w_empty ? 4'd0 : r_mem[r_rd_ptr];
  assign start_address = r_start_address;
  assign end_address   = r_end_address;
  assign play_start    = r_play_start;

  // Queue storage write; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_id;
    end
  end

  // Queue pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Playback FSM with registered play_start, busy, err and address outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_play_start    <= 1'b0;
      r_busy          <= 1'b0;
      r_err           <= 1'b0;
      r_start_address <= '0;
      r_end_address   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end

        S_LOAD: begin
          if (w_empty) begin
            // Queue was flushed between the decision and the load.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (lut_end >= lut_start) begin
            r_start_address <= lut_start;
            r_end_address   <= lut_end;
            r_play_start    <= 1'b1;
            r_cnt           <= '0;
            r_state         <= S_START;
          end else begin
            // Inverted range from the table: skip the phrase, flag it.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        S_START: begin
          if (!play_finish) begin
            r_play_start <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_PLAY;
          end else if (w_tmo_hit) begin
            // Controller never acknowledged; give up on this phrase.
            r_err        <= 1'b1;
            r_play_start <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_GAP;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_PLAY: begin
          if (play_finish) begin
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end

        S_GAP: begin
          if (w_gap_hit) begin
            r_cnt <= '0;
            if (!w_empty) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_play_start <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phrase_sequencer.sv
// Bench for phrase_sequencer: random address table and phrase ids, an
// audio-controller stand-in driven from the stimulus flow, and a queue model
// that predicts which phrase each play_start must carry and the cycle timing.
module tb_phrase_sequencer;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] GAP    = 32'd10;
  localparam logic [31:0] ACK    = 32'd64;
  localparam logic [3:0]  BAD_ID = 4'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [3:0]  push_id;
  logic        flush;
  logic        full;
  logic        empty;
  logic        busy;
  logic        err;
  logic [3:0]  lut_id;
  logic [23:0] lut_start;
  logic [23:0] lut_end;
  logic [23:0] start_address;
  logic [23:0] end_address;
  logic        play_start;
  logic        play_finish;

  logic [23:0] t_start [16];
  logic [23:0] t_end   [16];
  logic [3:0]  mq [$];
  logic [3:0]  cur_id;
  logic        exp_err;
  int          total = 0;
  int          bad   = 0;

  phrase_sequencer #(
    .DEPTH(DEPTH),
    .GAP_CYCLES(GAP),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_id(push_id),
    .flush(flush),
    .full(full),
    .empty(empty),
    .busy(busy),
    .err(err),
    .lut_id(lut_id),
    .lut_start(lut_start),
    .lut_end(lut_end),
    .start_address(start_address),
    .end_address(end_address),
    .play_start(play_start),
    .play_finish(play_finish)
  );

  always #5 clk = ~clk;

  // External address table, combinational on lut_id.
  always_comb begin
    lut_start = t_start[lut_id];
    lut_end   = t_end[lut_id];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rand_id();
    logic [3:0] v;
    do v = 4'($urandom_range(0, 15)); while (v == BAD_ID);
    return v;
  endfunction

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_empty"}, empty, 1);
    chk({pfx, "_full"}, full, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_play_start"}, play_start, 0);
    chk({pfx, "_start_addr"}, start_address, 0);
    chk({pfx, "_end_addr"}, end_address, 0);
    chk({pfx, "_lut_id"}, lut_id, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b0; flush = 1'b0; push_id = 4'd0; play_finish = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    exp_err = 1'b0;
    chk_reset_state("reset");
  endtask

  // Model: a push lands unless the queue is full; 'forced' marks a push that
  // coincides with a pop, which a full queue must still accept.
  task automatic push_one(input logic [3:0] id, input bit forced);
    push = 1'b1; push_id = id;
    tick();
    push = 1'b0;
    if (forced || mq.size() < DEPTH) mq.push_back(id);
  endtask

  // Wait for play_start, check the phrase it carries, then acknowledge.
  task automatic serve_begin(input int ack_dly);
    int n;
    n = 0;
    while (play_start !== 1'b1 && n < 400) begin tick(); n++; end
    chk("start_seen", play_start, 1);
    cur_id = (mq.size() > 0) ? mq.pop_front() : 4'd0;
    chk("start_addr", start_address, t_start[cur_id]);
    chk("end_addr", end_address, t_end[cur_id]);
    chk("busy_in_start", busy, 1);
    chk("err_in_start", err, exp_err);
    repeat (ack_dly) tick();
    chk("start_held", play_start, 1);
    play_finish = 1'b0;
    tick();
    chk("start_dropped", play_start, 0);
  endtask

  // Hold the controller busy, check stability, then report idle.
  task automatic serve_end(input int len);
    repeat (len) tick();
    chk("busy_in_play", busy, 1);
    chk("addr_stable", start_address, t_start[cur_id]);
    chk("end_stable", end_address, t_end[cur_id]);
    chk("low_in_play", play_start, 0);
    play_finish = 1'b1;
  endtask

  // After play_finish rises: one cycle to notice, GAP silent cycles, then
  // one LOAD cycle before the next START, or straight back to idle.
  task automatic gap_next(input bit more);
    int n;
    n = 0;
    do begin tick(); n++; end
    while (play_start !== 1'b1 && busy === 1'b1 && n < int'(GAP) + 20);
    if (more) begin
      chk("gap_to_next_start", n, GAP + 2);
      chk("next_start", play_start, 1);
    end else begin
      chk("gap_to_idle", n, GAP + 1);
      chk("idle_busy", busy, 0);
      chk("idle_no_start", play_start, 0);
    end
  endtask

  initial begin
    int n;
    logic saw;
    logic [3:0] a;
    logic [3:0] b;

    reset = 1'b1; push = 1'b0; flush = 1'b0; push_id = 4'd0; play_finish = 1'b1;
    exp_err = 1'b0; cur_id = 4'd0;
    for (int i = 0; i < 16; i++) begin
      t_start[i] = 24'($urandom_range(0, 32'hEF_FFFF));
      t_end[i]   = t_start[i] + 24'($urandom_range(0, 32'hFFFF));
    end
    t_start[3] = 24'h000100;  t_end[3] = 24'h0001FF;
    t_start[4] = 24'h012345;  t_end[4] = 24'h012345;   // single-byte range is legal
    t_start[BAD_ID] = 24'h000200; t_end[BAD_ID] = 24'h0001FF;

    do_reset();

    // Single phrase: latency, addresses, gap back to idle.
    push_one(4'd3, 1'b0);
    chk("head_lut_id", lut_id, 3);
    chk("head_not_empty", empty, 0);
    n = 1;
    while (play_start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("push_to_start", n, 3);
    serve_begin(2);
    serve_end(400);
    gap_next(1'b0);
    chk("single_empty", empty, 1);
    chk("single_err", err, 0);

    // Back-to-back pushes play in order with exact gaps.
    push_one(4'd1, 1'b0);
    push_one(4'd2, 1'b0);
    push_one(4'd5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      serve_begin($urandom_range(1, 6));
      serve_end($urandom_range(3, 30));
      gap_next(k < 2);
    end

    // Random bursts.
    for (int r = 0; r < 4; r++) begin
      int cnt;
      cnt = $urandom_range(1, 4);
      for (int j = 0; j < cnt; j++) push_one(rand_id(), 1'b0);
      while (mq.size() > 0) begin
        serve_begin($urandom_range(0, 8));
        serve_end($urandom_range(1, 25));
        gap_next(mq.size() > 0);
      end
    end

    // Inverted table range: error, no playback, back to idle.
    saw = 1'b0;
    push = 1'b1; push_id = BAD_ID;
    tick();
    push = 1'b0;
    saw = saw | play_start;
    tick();
    saw = saw | play_start;
    tick();
    saw = saw | play_start;
    chk("bad_range_err", err, 1);
    chk("bad_range_busy", busy, 0);
    chk("bad_range_empty", empty, 1);
    repeat (5) begin tick(); saw = saw | play_start; end
    chk("bad_range_no_start", saw, 0);
    do_reset();

    // Controller never acknowledges: timeout, gap, next phrase still plays.
    a = rand_id();
    b = rand_id();
    push_one(a, 1'b0);
    push_one(b, 1'b0);
    n = 0;
    while (play_start !== 1'b1 && n < 40) begin tick(); n++; end
    cur_id = mq.pop_front();
    chk("tmo_start_addr", start_address, t_start[cur_id]);
    n = 0;
    while (play_start === 1'b1 && n < int'(ACK) + 10) begin tick(); n++; end
    chk("tmo_start_len", n, ACK);
    exp_err = 1'b1;
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 1);
    n = 0;
    while (play_start !== 1'b1 && n < int'(GAP) + 20) begin tick(); n++; end
    chk("tmo_gap_to_next", n, GAP + 1);
    serve_begin(3);
    serve_end(12);
    gap_next(1'b0);
    chk("tmo_err_sticky", err, 1);
    do_reset();

    // Fill while blocked in PLAY; 9th push dropped; push with pop accepted.
    push_one(rand_id(), 1'b0);
    serve_begin(2);
    for (int i = 0; i < DEPTH; i++) begin
      push_one(rand_id(), 1'b0);
      chk("fill_full", full, (i == DEPTH - 1));
    end
    push_one(rand_id(), 1'b0);
    chk("drop_full", full, 1);
    chk("drop_not_empty", empty, 0);
    serve_end(20);
    repeat (int'(GAP) + 1) tick();
    chk("load_still_full", full, 1);
    push_one(rand_id(), 1'b1);
    chk("pop_push_start", play_start, 1);
    chk("pop_push_full", full, 1);
    while (mq.size() > 0) begin
      serve_begin($urandom_range(1, 5));
      serve_end($urandom_range(2, 20));
      gap_next(mq.size() > 0);
    end
    chk("drain_empty", empty, 1);

    // Flush while playing: queue empties at once, current phrase completes.
    push_one(rand_id(), 1'b0);
    serve_begin(2);
    for (int i = 0; i < 3; i++) push_one(rand_id(), 1'b0);
    flush = 1'b1; push = 1'b1; push_id = rand_id();
    tick();
    flush = 1'b0; push = 1'b0;
    mq.delete();
    chk("flush_empty", empty, 1);
    chk("flush_lut_id", lut_id, 0);
    chk("flush_busy", busy, 1);
    serve_end(15);
    gap_next(1'b0);

    // Reset while playing.
    push_one(rand_id(), 1'b0);
    push_one(rand_id(), 1'b0);
    serve_begin(2);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk_reset_state("mid_reset");
    reset = 1'b0;
    play_finish = 1'b1;
    mq.delete();
    exp_err = 1'b0;
    repeat (4) tick();
    chk("post_reset_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phrase_sequencer.md
PHRASE_SEQUENCER -- requirements
Module: phrase_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: phrase queue depth, power of two.
REQ-002 Parameter GAP_CYCLES, default 32'd2500000: silent clk cycles between consecutive phrases (50 ms at 50 MHz).
REQ-003 Parameter ACK_TIMEOUT, default 32'd64: max clk cycles to wait for play_finish to fall after play_start.
REQ-004 clk  input  1  50 MHz system clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 push  input  1  enqueue push_id this cycle.
REQ-007 push_id  input  4  phrase index (digit/operator word) to enqueue.
REQ-008 flush  input  1  discard all queued phrases.
REQ-009 full / empty  output  1 each  queue status.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 err  output  1  sticky error flag.
REQ-012 lut_id  output  4  phrase index at queue head, to external address table.
REQ-013 lut_start / lut_end  input  24 each  byte addresses for lut_id, combinational from table.
REQ-014 start_address / end_address  output  24 each  byte range to audio controller.
REQ-015 play_start  output  1  start request to audio controller.
REQ-016 play_finish  input  1  audio controller idle indication (high = idle).

Function
REQ-017 Queue: DEPTH-entry FIFO, count 0..DEPTH; full = (count==DEPTH), empty = (count==0).
REQ-018 Push accepted when !full, or when full and a pop occurs the same cycle; push when full without pop is dropped, no error.
REQ-019 flush empties queue next cycle, overrides push the same cycle; in-progress phrase continues to completion.
REQ-020 lut_id = head entry whenever !empty; 4'd0 when empty.
REQ-021 States: IDLE, LOAD, START, PLAY, GAP.
REQ-022 IDLE: if !empty -> LOAD.
REQ-023 LOAD (one cycle): pop head; if lut_end >= lut_start, register lut_start/lut_end into start_address/end_address and -> START; else set err, no playback, -> IDLE.
REQ-024 START: play_start=1; on play_finish==0 -> PLAY; if ACK_TIMEOUT cycles elapse in START with play_finish still 1, set err and -> GAP.
REQ-025 PLAY: play_start=0; on play_finish==1 -> GAP.
REQ-026 GAP: count GAP_CYCLES clk cycles, then -> LOAD if !empty, else -> IDLE.
REQ-027 play_start high only in START; drops the cycle after START is left.
REQ-028 start_address/end_address change only in LOAD; stable through START, PLAY, GAP.
REQ-029 Latency: push into empty queue while IDLE -> play_start high exactly 3 cycles later (IDLE sees !empty, LOAD, START).
REQ-030 err cleared only by reset.
REQ-031 Counters (timeout, gap) are 32-bit, clear on state entry, never wrap.

Reset
REQ-032 reset high at posedge: state=IDLE, queue empty, count=0, play_start=0, busy=0, err=0, start_address=end_address=0, counters=0.
REQ-033 reset mid-phrase: play_start drops next cycle; downstream audio controller not reset by this block.

Verification
REQ-034 Reset, push id 3 with lut 0x000100/0x0001FF, play_finish falls 2 cycles after play_start, rises 400 cycles later -> start_address=0x000100, end_address=0x0001FF, play_start high 3 cycles after push, busy through GAP, empty=1.
REQ-035 Push ids 1,2,5 back to back (GAP_CYCLES=10) -> three phrases in order, exactly 10 idle cycles between each play_finish rise and next LOAD.
REQ-036 Push 9 ids with DEPTH=8 while IDLE blocked (play_finish held 1 then 0) -> 9th dropped unless same-cycle pop; full=1, count never exceeds 8.
REQ-037 play_finish held 1 after play_start -> err=1 after 64 cycles, play_start=0, sequencer proceeds to GAP then next phrase.
REQ-038 lut_start=0x000200, lut_end=0x0001FF -> err=1, play_start never asserted, state returns to IDLE.
REQ-039 flush during PLAY with 3 queued -> empty=1 next cycle, current phrase completes, then GAP -> IDLE; reset during PLAY -> all outputs at reset values next cycle.
